md5_iter_core: RTL and testbench
================================

# md5_iter_core

Parametrised iterative MD5 compression core for the hash-breaker datapath. It accepts one pre-padded 512-bit block per transaction with valid/ready handshakes. The block runs through 64 MD5 steps, folding STEPS_PER_CYCLE steps into each clock. It returns the 128-bit digest with a caller tag. Several instances sit side by side behind the candidate generator as a lower-area alternative to the fully unrolled 64-stage step pipeline.

## Interface
- STEPS_PER_CYCLE, 4, MD5 steps evaluated per clock; legal values 1, 2, 4, 8, 16. N = 64/STEPS_PER_CYCLE.
- TAG_W, 8, width of the opaque candidate tag carried alongside the block.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous abort; drops any job in flight.
- in_valid  in  1  block offered.
- in_ready  out  1  core can accept a block.
- in_block  in  512  padded message block; byte 0 in [511:504], byte 63 in [7:0].
- in_tag  in  TAG_W  candidate ID.
- out_valid  out  1  digest available.
- out_ready  in  1  consumer takes digest.
- out_digest  out  128  MD5 digest; digest byte 0 in [127:120].
- out_tag  out  TAG_W  tag of the accepted block.
- busy  out  1  high in RUN or DONE.

## Operation
- Message word W[j] (j = 0..15) is in_block[480-32*j +: 32] with its four bytes reversed, so it reads little-endian.
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: in_ready = 1. An accept (in_valid & in_ready at an edge) latches in_block and in_tag, loads A,B,C,D with the IV (67452301, efcdab89, 98badcfe, 10325476), clears the step counter and goes to RUN.
  - RUN: each edge applies steps i = cnt .. cnt+STEPS_PER_CYCLE-1 combinationally chained, then cnt += STEPS_PER_CYCLE. On the edge that completes step 63, the core adds the IV to A..D, registers the digest, asserts out_valid and goes to DONE.
  - DONE: out_valid = 1. out_digest and out_tag hold stable until out_valid & out_ready at an edge, which returns the core to IDLE.
- Step i, all arithmetic mod 2^32:
  - t = A + F_i(B,C,D) + K[i] + W[g_i].
  - New state is (A,B,C,D) <= (D, B + rotl(t, s_i), B, C).
  - rotl is a true 32-bit left rotate of the whole of t.
- Round functions:
  - i 0-15: F = (B&C)|(~B&D), g = i.
  - i 16-31: F = (D&B)|(~D&C), g = (5i+1)%16.
  - i 32-47: F = B^C^D, g = (3i+5)%16.
  - i 48-63: F = C^(B|~D), g = 7i%16.
- K[i] = floor(|sin(i+1)|·2^32), held as a constant table.
- s_i cycles by round as 7,12,17,22 / 5,9,14,20 / 4,11,16,23 / 6,10,15,21.
- out_digest = {bswap(A+IVa), bswap(B+IVb), bswap(C+IVc), bswap(D+IVd)}, which gives standard hex-string order.
- in_ready is low in RUN and DONE; inputs offered there are ignored, not queued.
- flush high at an edge forces IDLE from any state and clears out_valid; the in-flight result is lost.
- flush has priority over accept and over the out handshake in the same cycle.

## Timing
- Reset values:
  - state IDLE, cnt 0, A..D 0.
  - out_valid 0, out_digest 0, out_tag 0, busy 0.
  - in_ready 0 while rst is high, and 1 on the first cycle after release.
- Latency: if a block is accepted at edge E0, out_valid rises after edge E0+N (N = 16 with the default).
- Best-case issue interval is N+2 cycles: accept, N RUN edges, one DONE handshake edge, then IDLE again.
- out_ready held low leaves DONE outputs unchanged indefinitely.
- rst asserted mid-RUN or mid-DONE immediately returns all outputs to their reset values with no clock needed; the job is discarded.
- Critical path is STEPS_PER_CYCLE chained adders and rotates. The 64-step count and latency formula hold for every legal parameter value.

## Test plan
- Empty message: in_block = 0x80 followed by 63 zero bytes, tag 0x5A, out_ready = 1 -> out_digest = d41d8cd98f00b204e9800998ecf8427e, out_tag = 0x5A, out_valid rising exactly N cycles after accept.
- "abc": bytes 61 62 63 80, zeros, byte 56 = 0x18, run at STEPS_PER_CYCLE = 1, 4 and 16 -> digest 900150983cd24fb0d6963f7d28e17f72 every time, with latency 64, 16 and 4.
- Backpressure: out_ready held low for 20 cycles after out_valid -> digest and tag stable, in_ready = 0 throughout, in_valid pulses ignored; releasing out_ready gives IDLE on the next edge.
- Flush mid-RUN at step 32, then accept "abc" -> no output for the first job, correct "abc" digest with its own tag.
- Async rst pulse between edges during RUN -> outputs zero immediately. After release, an empty-message job yields d41d8cd98f00b204e9800998ecf8427e.
- Back-to-back: 8 random padded blocks with random tags under random in_valid/out_ready -> digests match the reference model, in order, issue interval ≥ N+2.

Source files
------------

// File: rtl/md5_iter_core.sv
// Iterative MD5 compression core: one pre-padded 512-bit block per job,
// STEPS_PER_CYCLE chained steps per clock, digest returned with the caller tag.
`timescale 1ns/1ps
module md5_iter_core #(
  parameter int unsigned STEPS_PER_CYCLE = 4,
  parameter int unsigned TAG_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_block,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_digest,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [5:0] CNT_STEP = 6'(STEPS_PER_CYCLE);
  localparam logic [5:0] CNT_LAST = 6'(64 - STEPS_PER_CYCLE);

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts indexed by {round, step[1:0]}
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q;
  logic [31:0]        a_q, b_q, c_q, d_q;
  logic [31:0]        a_n, b_n, c_n, d_n;
  logic [511:0]       block_q;
  logic [TAG_W-1:0]   tag_q;
  logic [127:0]       digest_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic [31:0]        w [16];
  logic               accept, run_step, finish;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Top half of {x,x} shifted left is the 32-bit left rotate.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] dbl;
    dbl = {x, x} << s;
    return dbl[63:32];
  endfunction

  always_comb begin
    for (int unsigned j = 0; j < 16; j++) begin
      w[j] = bswap32(block_q[480 - 32*j +: 32]);
    end
  end

  always_comb begin : step_chain
    logic [31:0] a, b, c, d, f, t, rot;
    logic [5:0]  idx;
    logic [3:0]  g;
    logic [1:0]  rnd;
    a = a_q;
    b = b_q;
    c = c_q;
    d = d_q;
    f = '0;
    t = '0;
    rot = '0;
    idx = '0;
    g = '0;
    rnd = '0;
    for (int unsigned k = 0; k < STEPS_PER_CYCLE; k++) begin
      idx = cnt_q + 6'(k);
      rnd = idx[5:4];
      case (rnd)
        2'd0: begin f = (b & c) | (~b & d); g = idx[3:0];                end
        2'd1: begin f = (d & b) | (~d & c); g = idx[3:0] * 4'd5 + 4'd1; end
        2'd2: begin f = b ^ c ^ d;          g = idx[3:0] * 4'd3 + 4'd5; end
        default: begin f = c ^ (b | ~d);    g = idx[3:0] * 4'd7;        end
      endcase
      t   = a + f + K_TAB[idx] + w[g];
      rot = rotl32(t, S_TAB[{rnd, idx[1:0]}]);
      a = d;
      d = c;
      c = b;
      b = b + rot;
    end
    a_n = a;
    b_n = b;
    c_n = c;
    d_n = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_valid)             state_d = S_RUN;
        S_RUN:   if (cnt_q == CNT_LAST)    state_d = S_DONE;
        S_DONE:  if (out_ready)            state_d = S_IDLE;
        default:                           state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign accept   = (state_q == S_IDLE) && in_valid && !flush;
  assign run_step = (state_q == S_RUN) && !flush;
  assign finish   = run_step && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      block_q   <= '0;
      tag_q     <= '0;
      digest_q  <= '0;
      out_tag_q <= '0;
    end else begin
      if (accept) begin
        block_q <= in_block;
        tag_q   <= in_tag;
        a_q     <= IV_A;
        b_q     <= IV_B;
        c_q     <= IV_C;
        d_q     <= IV_D;
        cnt_q   <= '0;
      end else if (run_step) begin
        a_q   <= a_n;
        b_q   <= b_n;
        c_q   <= c_n;
        d_q   <= d_n;
        cnt_q <= cnt_q + CNT_STEP;
      end
      if (finish) begin
        digest_q  <= {bswap32(a_n + IV_A), bswap32(b_n + IV_B),
                      bswap32(c_n + IV_C), bswap32(d_n + IV_D)};
        out_tag_q <= tag_q;
      end
    end
  end

  assign out_digest = digest_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_md5_iter_core.sv
// Bench for md5_iter_core: three instances (4, 1 and 16 steps per clock)
// checked against a straight-line MD5 reference function.
`timescale 1ns/1ps
module tb_md5_iter_core;

  localparam int NSTEP [3] = '{4, 1, 16};

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         bsy  [3];
  logic [127:0] od   [3];
  logic [7:0]   ot   [3];
  logic [511:0] blk;
  logic [7:0]   tag;

  int checks = 0;
  int errors = 0;
  logic [31:0] ktab [64];

  localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 8'h18, 56'h0};

  always #5 clk = ~clk;

  md5_iter_core #(.STEPS_PER_CYCLE(4), .TAG_W(8)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_block(blk), .in_tag(tag), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_digest(od[0]), .out_tag(ot[0]), .busy(bsy[0]));

  md5_iter_core #(.STEPS_PER_CYCLE(1), .TAG_W(8)) u1 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_block(blk), .in_tag(tag), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_digest(od[1]), .out_tag(ot[1]), .busy(bsy[1]));

  md5_iter_core #(.STEPS_PER_CYCLE(16), .TAG_W(8)) u2 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_block(blk), .in_tag(tag), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_digest(od[2]), .out_tag(ot[2]), .busy(bsy[2]));

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] md5_ref(input logic [511:0] bin);
    logic [7:0]  by [64];
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t, tmp;
    logic [127:0] res;
    int g, s;
    int sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    for (int n = 0; n < 64; n++) by[n] = bin[511 - 8*n -: 8];
    for (int j = 0; j < 16; j++) m[j] = {by[4*j+3], by[4*j+2], by[4*j+1], by[4*j]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7*i) % 16;     end
      s = sh[(i / 16) * 4 + (i % 4)];
      t = a + f + ktab[i] + m[g];
      tmp = d;
      d = c;
      c = b;
      b = b + ((t << s) | (t >> (32 - s)));
      a = tmp;
    end
    a = a + 32'h67452301; b = b + 32'hefcdab89;
    c = c + 32'h98badcfe; d = d + 32'h10325476;
    for (int n = 0; n < 4; n++) begin
      res[127 - 8*n -: 8] = 8'(a >> (8*n));
      res[95  - 8*n -: 8] = 8'(b >> (8*n));
      res[63  - 8*n -: 8] = 8'(c >> (8*n));
      res[31  - 8*n -: 8] = 8'(d >> (8*n));
    end
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [7:0]   by [64];
    logic [511:0] r;
    logic [63:0]  bits;
    int len;
    len = int'($urandom_range(0, 55));
    for (int n = 0; n < 64; n++) by[n] = 8'h00;
    for (int n = 0; n < len; n++) by[n] = 8'($urandom);
    by[len] = 8'h80;
    bits = 64'(len * 8);
    for (int n = 0; n < 8; n++) by[56 + n] = 8'(bits >> (8*n));
    for (int n = 0; n < 64; n++) r[511 - 8*n -: 8] = by[n];
    return r;
  endfunction

  task automatic run_job(input int u, input logic [511:0] bk, input logic [7:0] tg, output int lat);
    int w;
    blk = bk;
    tag = tg;
    w = 0;
    while (!ir[u] && w < 200) begin @(posedge clk); #1; w++; end
    iv[u] = 1'b1;
    @(posedge clk); #1;
    iv[u] = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    int lat, sent, rcvd, cyc, last_acc;
    logic acc, hs;
    logic [511:0] rb, cur_blk;
    logic [7:0]   rt, cur_tag;
    logic [127:0] rexp, exp_q [$];
    logic [7:0]   tag_q [$];
    real r;

    rst = 1'b1;
    flush = 1'b0;
    blk = '0;
    tag = '0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      ktab[i] = 32'(longint'($floor(r * 4294967296.0)));
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(ir[0]), 128'd0);
    chk("rst_out_valid", 128'(ov[0]), 128'd0);
    chk("rst_digest", od[0], 128'd0);
    chk("rst_tag", 128'(ot[0]), 128'd0);
    chk("rst_busy", 128'(bsy[0]), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 128'(ir[0]), 128'd1);

    // Empty message
    chk("model_empty", md5_ref(BLK_EMPTY), DIG_EMPTY);
    chk("model_abc", md5_ref(BLK_ABC), DIG_ABC);
    run_job(0, BLK_EMPTY, 8'h5A, lat);
    chk("empty_latency", 128'(lat), 128'd16);
    chk("empty_digest", od[0], DIG_EMPTY);
    chk("empty_tag", 128'(ot[0]), 128'h5A);
    chk("empty_busy", 128'(bsy[0]), 128'd1);
    @(posedge clk); #1;
    chk("empty_release_valid", 128'(ov[0]), 128'd0);
    chk("empty_release_ready", 128'(ir[0]), 128'd1);

    // "abc" at 4, 1 and 16 steps per clock
    for (int u = 0; u < 3; u++) begin
      run_job(u, BLK_ABC, 8'(8'hA0 + u), lat);
      chk($sformatf("abc_latency_u%0d", u), 128'(lat), 128'(64 / NSTEP[u]));
      chk($sformatf("abc_digest_u%0d", u), od[u], DIG_ABC);
      chk($sformatf("abc_tag_u%0d", u), 128'(ot[u]), 128'(8'hA0 + u));
      @(posedge clk); #1;
    end

    // Backpressure with ignored in_valid pulses
    ordy[0] = 1'b0;
    rb = rand_block();
    rt = 8'($urandom);
    rexp = md5_ref(rb);
    run_job(0, rb, rt, lat);
    chk("bp_digest", od[0], rexp);
    for (int c = 0; c < 20; c++) begin
      iv[0] = 1'($urandom_range(0, 1));
      blk = rand_block();
      tag = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_hold_digest", od[0], rexp);
      chk("bp_hold_tag", 128'(ot[0]), 128'(rt));
      chk("bp_in_ready", 128'(ir[0]), 128'd0);
      chk("bp_out_valid", 128'(ov[0]), 128'd1);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(ov[0]), 128'd0);
    chk("bp_release_ready", 128'(ir[0]), 128'd1);

    // Flush at step 32, then "abc"
    blk = rand_block();
    tag = 8'h11;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 128'(ov[0]), 128'd0);
    chk("flush_busy", 128'(bsy[0]), 128'd0);
    chk("flush_ready", 128'(ir[0]), 128'd1);
    run_job(0, BLK_ABC, 8'h77, lat);
    chk("flush_abc_latency", 128'(lat), 128'd16);
    chk("flush_abc_digest", od[0], DIG_ABC);
    chk("flush_abc_tag", 128'(ot[0]), 128'h77);
    @(posedge clk); #1;

    // Asynchronous reset between edges during RUN
    blk = rand_block();
    tag = 8'h42;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(ov[0]), 128'd0);
    chk("arst_busy", 128'(bsy[0]), 128'd0);
    chk("arst_ready", 128'(ir[0]), 128'd0);
    chk("arst_digest", od[0], 128'd0);
    chk("arst_tag", 128'(ot[0]), 128'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_release_ready", 128'(ir[0]), 128'd1);
    run_job(0, BLK_EMPTY, 8'h3C, lat);
    chk("arst_empty_latency", 128'(lat), 128'd16);
    chk("arst_empty_digest", od[0], DIG_EMPTY);
    chk("arst_empty_tag", 128'(ot[0]), 128'h3C);
    @(posedge clk); #1;

    // Back-to-back random jobs under random handshakes
    sent = 0;
    rcvd = 0;
    cyc = 0;
    last_acc = 0;
    blk = rand_block();
    tag = 8'($urandom);
    while (rcvd < 8 && cyc < 4000) begin
      iv[0] = (sent < 8) && ($urandom_range(0, 3) != 0);
      ordy[0] = ($urandom_range(0, 2) != 0);
      acc = iv[0] && ir[0];
      hs = ov[0] && ordy[0];
      if (hs) begin
        if (exp_q.size() > 0) begin
          chk("b2b_digest", od[0], exp_q.pop_front());
          chk("b2b_tag", 128'(ot[0]), 128'(tag_q.pop_front()));
        end else begin
          chk("b2b_unexpected_output", 128'd1, 128'(exp_q.size()));
        end
        rcvd++;
      end
      cur_blk = blk;
      cur_tag = tag;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        exp_q.push_back(md5_ref(cur_blk));
        tag_q.push_back(cur_tag);
        if (sent > 0) chk("b2b_interval_ge_18", 128'((cyc - last_acc) >= 18), 128'd1);
        last_acc = cyc;
        sent++;
        blk = rand_block();
        tag = 8'($urandom);
      end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("b2b_received", 128'(rcvd), 128'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
